// File: rtl/gram_arbiter_pkg.sv
// Shared constants for the gram frame-buffer arbiter: address geometry,
// FSM state encodings and initial bank assignments.
package gram_arbiter_pkg;
    localparam int ROW_W = 13;
    localparam int COL_W = 9;
    localparam int LVL_W = 10;
    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int CNT_W = 12;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE_WR = 3'd1;
    localparam logic [2:0] S_ISSUE_RD = 3'd2;
    localparam logic [2:0] S_WAIT_HI  = 3'd3;
    localparam logic [2:0] S_WAIT_LO  = 3'd4;

    localparam logic [1:0] WR_BANK_INIT = 2'b00;
    localparam logic [1:0] RD_BANK_INIT = 2'b11;

    function automatic logic [AW-1:0] mk_addr(input logic [1:0] bank, input logic [ROW_W-1:0] row);
        return {bank, row, {COL_W{1'b0}}};
    endfunction
endpackage

// File: rtl/gram_arbiter_if.sv
// FIFO-level / sdram_core handshake bundle seen by the arbiter.
interface gram_arbiter_if;
    import gram_arbiter_pkg::*;

    logic             init_done;
    logic [LVL_W-1:0] wr_level;
    logic [LVL_W-1:0] rd_level;
    logic             wr_busy;
    logic             rd_busy;
    logic             wr_request;
    logic             rd_request;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             wr_frame;
    logic             rd_frame;
    logic             rd_repeat;
    logic             err;

    modport master (
        input  init_done, wr_level, rd_level, wr_busy, rd_busy,
        output wr_request, rd_request, wr_addr, rd_addr, wr_frame, rd_frame, rd_repeat, err
    );
    modport slave (
        output init_done, wr_level, rd_level, wr_busy, rd_busy,
        input  wr_request, rd_request, wr_addr, rd_addr, wr_frame, rd_frame, rd_repeat, err
    );
endinterface

// File: rtl/gram_arbiter_frame_ptr.sv
// Row counter plus bank register for one side of the ping-pong frame buffer.
// The bank flips at frame end only when i_cond_toggle is set.
module gram_arbiter_frame_ptr
    import gram_arbiter_pkg::*;
#(
    parameter int         ROWS      = 1200,
    parameter logic [1:0] BANK_INIT = 2'b00
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    input  logic             i_cond_toggle,
    output logic [ROW_W-1:0] o_row,
    output logic [1:0]       o_bank,
    output logic             o_last,
    output logic             o_frame
);
    logic [ROW_W-1:0] r_row;
    logic [1:0]       r_bank;
    logic             r_frame;
    logic             w_last;

    assign w_last = (r_row == ROW_W'(ROWS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_row   <= '0;
            r_bank  <= BANK_INIT;
            r_frame <= 1'b0;
        end else begin
            r_frame <= i_adv & w_last;
            if (i_adv) begin
                if (w_last) begin
                    r_row <= '0;
                    if (i_cond_toggle)
                        r_bank <= ~r_bank;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end
        end
    end

    assign o_row   = r_row;
    assign o_bank  = r_bank;
    assign o_last  = w_last;
    assign o_frame = r_frame;
endmodule

// File: rtl/gram_arbiter.sv
// Grants one SDRAM burst at a time between the CMOS write FIFO and the VGA
// read FIFO, and tracks ping-pong frame banks for both sides.
module gram_arbiter
    import gram_arbiter_pkg::*;
#(
    parameter int BURST_LEN      = 256,
    parameter int ROWS_PER_FRAME = 1200,
    parameter int RD_URGENT      = 128,
    parameter int WR_URGENT      = 384,
    parameter int TIMEOUT        = 4095
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    gram_arbiter_if.master        io_bus
);
    logic [2:0]       r_state;
    logic             r_last_wr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_rd_repeat;

    logic             w_wr_ok, w_rd_ok, w_wr_urg, w_rd_urg, w_grant_rd, w_grant_wr;
    logic             w_busy, w_timeout, w_done, w_wr_adv, w_rd_adv, w_rd_cond;
    logic [ROW_W-1:0] w_wr_row, w_rd_row;
    logic [1:0]       w_wr_bank, w_rd_bank;
    logic             w_wr_last, w_rd_last, w_wr_frame, w_rd_frame;

    assign w_wr_ok  = io_bus.init_done & (io_bus.wr_level >= LVL_W'(BURST_LEN)) & ~io_bus.wr_busy;
    assign w_rd_ok  = io_bus.init_done & (io_bus.rd_level <  LVL_W'(BURST_LEN)) & ~io_bus.rd_busy;
    assign w_rd_urg = w_rd_ok & (io_bus.rd_level <  LVL_W'(RD_URGENT));
    assign w_wr_urg = w_wr_ok & (io_bus.wr_level >= LVL_W'(WR_URGENT));

    // Urgent read beats everything; otherwise an urgent write, else alternate.
    assign w_grant_rd = w_rd_ok & (w_rd_urg | ~w_wr_ok | (~w_wr_urg & r_last_wr));
    assign w_grant_wr = w_wr_ok & ~w_grant_rd;

    assign w_busy    = r_last_wr ? io_bus.wr_busy : io_bus.rd_busy;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));
    assign w_done    = (r_state == S_WAIT_LO) & ~w_busy;
    assign w_wr_adv  = w_done &  r_last_wr;
    assign w_rd_adv  = w_done & ~r_last_wr;
    // Reader only moves to the other bank once the writer has left it.
    assign w_rd_cond = (w_rd_bank == w_wr_bank);

    gram_arbiter_frame_ptr #(.ROWS(ROWS_PER_FRAME), .BANK_INIT(WR_BANK_INIT)) u_wr_ptr (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_adv(w_wr_adv), .i_cond_toggle(1'b1),
        .o_row(w_wr_row), .o_bank(w_wr_bank), .o_last(w_wr_last), .o_frame(w_wr_frame)
    );

    gram_arbiter_frame_ptr #(.ROWS(ROWS_PER_FRAME), .BANK_INIT(RD_BANK_INIT)) u_rd_ptr (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_adv(w_rd_adv), .i_cond_toggle(w_rd_cond),
        .o_row(w_rd_row), .o_bank(w_rd_bank), .o_last(w_rd_last), .o_frame(w_rd_frame)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_last_wr   <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rd_repeat <= 1'b0;
        end else begin
            r_rd_repeat <= w_rd_adv & w_rd_last & ~w_rd_cond;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_rd) begin
                        r_state   <= S_ISSUE_RD;
                        r_last_wr <= 1'b0;
                    end else if (w_grant_wr) begin
                        r_state   <= S_ISSUE_WR;
                        r_last_wr <= 1'b1;
                    end
                end
                S_ISSUE_WR, S_ISSUE_RD: begin
                    r_state <= S_WAIT_HI;
                    r_cnt   <= '0;
                end
                S_WAIT_HI: begin
                    if (w_busy) begin
                        r_state <= S_WAIT_LO;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!w_busy) begin
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.wr_request = (r_state == S_ISSUE_WR);
    assign io_bus.rd_request = (r_state == S_ISSUE_RD);
    assign io_bus.wr_addr    = mk_addr(w_wr_bank, w_wr_row);
    assign io_bus.rd_addr    = mk_addr(w_rd_bank, w_rd_row);
    assign io_bus.wr_frame   = w_wr_frame;
    assign io_bus.rd_frame   = w_rd_frame;
    assign io_bus.rd_repeat  = r_rd_repeat;
    assign io_bus.err        = r_err;
endmodule
